pipe_ctrl_gen: RTL and testbench
================================

Name: pipe_ctrl_gen

Overview:
- Parametrised pipeline stall/flush controller; successor to the fixed 5-stage core controller.
- Merges N stall requesters, each with its own stall depth, into a thermometer stall vector plus a bubble-flush vector.
- Adds sequential behaviour the current controller lacks: fence-drain FSM, WFI sleep FSM, multi-cycle redirect flush hold, and a stall watchdog.
- Sits beside the pipeline registers; drives every IF/ID/EX/MEM/WB boundary.

Parameters:
- NUM_STAGES, 5, pipeline stages; stall width NUM_STAGES, flush width NUM_STAGES-1.
- NUM_REQ, 6, number of generic stall requesters.
- DW, $clog2(NUM_STAGES+1), width of one depth field.
- FENCE_DEPTH, 2, stall depth applied while draining a fence.
- REDIRECT_DEPTH, 2, number of low flush bits set on a branch or exception.
- REDIRECT_HOLD, 1, cycles the redirect flush is held (≥1).
- TIMEOUT, 1023, stall-cycle count that raises stall_timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall_req  in  NUM_REQ  per-requester stall request
- stall_depth  in  NUM_REQ*DW  depth d of requester i in bits [i*DW+:DW]; stalls stages 0..d-1
- branch_flag  in  1  EX redirect
- excp_flag  in  1  CSR exception/interrupt redirect
- split16_flag  in  1  compressed-instruction split; flush[0]
- fence_req  in  1  decode holds a fence
- lsu_busy  in  NUM_STAGES  per-stage load/store occupancy
- wfi_req  in  1  decode holds WFI
- wake_req  in  1  wake/clear WFI
- stall  out  NUM_STAGES  bit k=1 holds stage k
- flush  out  NUM_STAGES-1  bit k=1 bubbles the register between stage k and k+1
- sleeping  out  1  FSM in SLEEP
- stall_timeout  out  1  watchdog tripped

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1 (combinational override):
  - stall=0, flush=all 1s, sleeping=0, stall_timeout=0.
  - Next state RUN; hold counter 0; watchdog 0.
- Requester merge:
  - D = max of stall_depth over active requesters, clamped to NUM_STAGES.
  - stall[k] = (k < D).
  - flush[D-1] = 1 if 0 < D < NUM_STAGES.
  - D=0 has no effect.
- FSM states: RUN, FENCE_DRAIN, SLEEP.
  - RUN, wfi_req & !wake_req → SLEEP.
  - RUN, fence_req & |lsu_busy → FENCE_DRAIN (wfi takes priority).
  - FENCE_DRAIN: effective depth = max(D, FENCE_DEPTH).
  - FENCE_DRAIN → RUN in the first cycle lsu_busy==0; that cycle is still stalled, and the release takes effect the next cycle.
  - SLEEP: stall = all 1s, flush = 0 except redirect bits; SLEEP → RUN on wake_req | excp_flag, so stall drops the next cycle.
  - wfi_req and wake_req in the same cycle: stay RUN, no WFI stall.
  - excp_flag in any state forces next state RUN.
- Redirect:
  - branch_flag | excp_flag sets flush[REDIRECT_DEPTH-1:0] combinationally that cycle.
  - Loads the hold counter with REDIRECT_HOLD-1; flush bits stay set while counter ≠ 0, decrementing each cycle.
  - A new redirect reloads the counter.
  - Redirect never clears stall bits.
- split16_flag ORs into flush[0].
- Final flush = merge bubble | fence bubble | redirect bits | split bit.
- Watchdog:
  - 10+ bit saturating counter; increments when stall[0] & state≠SLEEP, clears when stall[0]=0.
  - stall_timeout = (count ≥ TIMEOUT); it is sticky until stall[0] falls or rst.
- stall and flush are combinational from inputs plus registered state.
- sleeping and stall_timeout are registered-state derived; no added input-to-output latency.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {RUN, FENCE_DRAIN, SLEEP}.
  - localparams for state encoding and default widths.
  - Function depth_to_therm(depth, n).
- Sub-module stall_depth_arbiter: max-reduce of NUM_REQ depth fields to thermometer stall plus one-hot bubble. Instantiated once; the FSM feeds FENCE_DEPTH as an extra requester.

Test Plan:
- Merge: req0 depth 2, req3 depth 4 same cycle → stall=5'b01111, flush=4'b1000. Release → both 0 the next comb eval.
- Fence: fence_req with lsu_busy=5'b01000 for 3 cycles → FENCE_DRAIN; stall=5'b00011, flush=4'b0010 for 4 cycles. Then stall=0.
- WFI: wfi_req → next cycle sleeping=1, stall=5'b11111. wake_req → next cycle sleeping=0, stall=0. wfi_req and wake_req together → no sleep.
- Redirect hold: REDIRECT_HOLD=3, branch_flag pulse → flush[1:0]=2'b11 for exactly 3 cycles. A second pulse at cycle 2 extends through cycle 4.
- Watchdog: TIMEOUT=8, constant depth-1 stall → stall_timeout rises after the 8th stalled cycle. Drop req → clears next cycle. No increment in SLEEP.
- Reset mid-sleep: SLEEP then rst=1 one cycle → flush=4'b1111, stall=0. After rst, state RUN, sleeping=0, watchdog count 0.

Source files
------------

// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int STATE_W        = 2;
  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_NUM_REQ    = 6;
  localparam int MAX_STAGES     = 32;

  typedef enum logic [STATE_W-1:0] {
    RUN         = 2'd0,
    FENCE_DRAIN = 2'd1,
    SLEEP       = 2'd2
  } ctrlStateT;

  // Thermometer code: bits 0..depth-1 set, never beyond stage count n.
  function automatic logic [MAX_STAGES-1:0] depth_to_therm(input int depth, input int n);
    logic [MAX_STAGES-1:0] therm;
    therm = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      therm[i] = (i < depth) && (i < n);
    end
    return therm;
  endfunction

endpackage

// File: rtl/pipe_ctrl_gen_arbiter.sv
// Max-reduces per-requester stall depths into a thermometer stall vector
// and a one-hot bubble marking the boundary just below the stalled region.
module stall_depth_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DW         = $clog2(NUM_STAGES + 1)
) (
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] depth,
  output logic [NUM_STAGES-1:0] stallVec,
  output logic [NUM_STAGES-2:0] bubble
);

  logic [DW-1:0] maskedDepth [NUM_REQ];
  int            maxDepth;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : genMask
      assign maskedDepth[gi] = req[gi] ? depth[gi*DW +: DW] : '0;
    end
  endgenerate

  // Largest active depth, clamped to the pipeline length, then encoded.
  always_comb begin
    maxDepth = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(maskedDepth[i]) > maxDepth) maxDepth = int'(maskedDepth[i]);
    end
    if (maxDepth > NUM_STAGES) maxDepth = NUM_STAGES;
    stallVec = NUM_STAGES'(depth_to_therm(maxDepth, NUM_STAGES));
    // Bubble at boundary D-1; D=0 and D=NUM_STAGES never match an index.
    for (int k = 0; k < NUM_STAGES - 1; k++) begin
      bubble[k] = (maxDepth == k + 1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: requester merge, fence drain, WFI sleep,
// redirect flush hold and stall watchdog.
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DW             = $clog2(NUM_STAGES + 1),
  parameter int FENCE_DEPTH    = 2,
  parameter int REDIRECT_DEPTH = 2,
  parameter int REDIRECT_HOLD  = 1,
  parameter int TIMEOUT        = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stall_req,
  input  logic [NUM_REQ*DW-1:0] stall_depth,
  input  logic                  branch_flag,
  input  logic                  excp_flag,
  input  logic                  split16_flag,
  input  logic                  fence_req,
  input  logic [NUM_STAGES-1:0] lsu_busy,
  input  logic                  wfi_req,
  input  logic                  wake_req,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-2:0] flush,
  output logic                  sleeping,
  output logic                  stall_timeout
);

  localparam int HCW = (REDIRECT_HOLD > 1) ? $clog2(REDIRECT_HOLD) : 1;
  localparam int WDW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [HCW-1:0] HOLD_LOAD   = HCW'(REDIRECT_HOLD - 1);
  localparam logic [WDW-1:0] TIMEOUT_VAL = WDW'(TIMEOUT);

  ctrlStateT               stateReg;
  logic                    sleepingReg;
  logic [HCW-1:0]          holdCntReg;
  logic [WDW-1:0]          wdCntReg;

  logic                    busyAny;
  logic                    redirect;
  logic                    redirActive;
  logic                    wfiGo;
  logic                    fenceActive;
  logic [NUM_REQ:0]        arbReq;
  logic [(NUM_REQ+1)*DW-1:0] arbDepth;
  logic [NUM_STAGES-1:0]   arbStall;
  logic [NUM_STAGES-2:0]   arbBubble;
  logic [NUM_STAGES-2:0]   redirBits;
  logic [NUM_STAGES-2:0]   splitBits;

  assign busyAny     = |lsu_busy;
  assign redirect    = branch_flag | excp_flag;
  assign redirActive = redirect | (holdCntReg != '0);
  assign wfiGo       = wfi_req & ~wake_req;
  // The entry cycle already holds the fence so it cannot issue before draining.
  assign fenceActive = (stateReg == FENCE_DRAIN) |
                       ((stateReg == RUN) & fence_req & busyAny & ~wfiGo);

  // The fence drain is just one more requester with a fixed depth.
  assign arbReq   = {fenceActive, stall_req};
  assign arbDepth = {DW'(FENCE_DEPTH), stall_depth};

  stall_depth_arbiter #(
    .NUM_STAGES(NUM_STAGES),
    .NUM_REQ   (NUM_REQ + 1),
    .DW        (DW)
  ) uArbiter (
    .req     (arbReq),
    .depth   (arbDepth),
    .stallVec(arbStall),
    .bubble  (arbBubble)
  );

  // Control FSM; exceptions always return the core to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= RUN;
      sleepingReg <= 1'b0;
    end else if (excp_flag) begin
      stateReg    <= RUN;
      sleepingReg <= 1'b0;
    end else begin
      case (stateReg)
        RUN: begin
          if (wfiGo) begin
            stateReg    <= SLEEP;
            sleepingReg <= 1'b1;
          end else if (fence_req && busyAny) begin
            stateReg <= FENCE_DRAIN;
          end
        end
        FENCE_DRAIN: begin
          if (!busyAny) stateReg <= RUN;
        end
        SLEEP: begin
          if (wake_req) begin
            stateReg    <= RUN;
            sleepingReg <= 1'b0;
          end
        end
        default: begin
          stateReg    <= RUN;
          sleepingReg <= 1'b0;
        end
      endcase
    end
  end

  // Redirect flush hold counter; every new redirect reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdCntReg <= '0;
    end else if (redirect) begin
      holdCntReg <= HOLD_LOAD;
    end else if (holdCntReg != '0) begin
      holdCntReg <= holdCntReg - 1'b1;
    end
  end

  // Stall/flush outputs: reset flushes everything, SLEEP freezes the pipe.
  always_comb begin
    for (int k = 0; k < NUM_STAGES - 1; k++) begin
      redirBits[k] = redirActive && (k < REDIRECT_DEPTH);
    end
    splitBits    = '0;
    splitBits[0] = split16_flag;
    if (rst) begin
      stall = '0;
      flush = '1;
    end else if (stateReg == SLEEP) begin
      stall = '1;
      flush = redirBits;
    end else begin
      stall = arbStall;
      flush = arbBubble | redirBits | splitBits;
    end
  end

  // Saturating stall watchdog; frozen while asleep, cleared when stage 0 moves.
  always_ff @(posedge clk) begin
    if (rst || !stall[0]) begin
      wdCntReg <= '0;
    end else if ((stateReg != SLEEP) && (wdCntReg != {WDW{1'b1}})) begin
      wdCntReg <= wdCntReg + 1'b1;
    end
  end

  assign sleeping      = sleepingReg & ~rst;
  assign stall_timeout = ~rst & (wdCntReg >= TIMEOUT_VAL);

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: stimulus queues expected outputs,
// a negedge monitor pops and compares one transaction per cycle.
module tb_pipe_ctrl_gen;

  localparam int NS = 5;
  localparam int NR = 6;
  localparam int DW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR-1:0]    stall_req;
  logic [NR*DW-1:0] stall_depth;
  logic             branch_flag, excp_flag, split16_flag, fence_req;
  logic [NS-1:0]    lsu_busy;
  logic             wfi_req, wake_req;
  logic [NS-1:0]    stall;
  logic [NS-2:0]    flush;
  logic             sleeping, stall_timeout;

  pipe_ctrl_gen #(
    .NUM_STAGES(NS), .NUM_REQ(NR), .DW(DW), .FENCE_DEPTH(2),
    .REDIRECT_DEPTH(2), .REDIRECT_HOLD(3), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .stall_depth(stall_depth),
    .branch_flag(branch_flag), .excp_flag(excp_flag), .split16_flag(split16_flag),
    .fence_req(fence_req), .lsu_busy(lsu_busy), .wfi_req(wfi_req), .wake_req(wake_req),
    .stall(stall), .flush(flush), .sleeping(sleeping), .stall_timeout(stall_timeout)
  );

  typedef struct {
    string         name;
    logic [NS-1:0] st;
    logic [NS-2:0] fl;
    logic          sl;
    logic          tmo;
  } expT;

  expT sbq[$];
  expT mon;
  int  passCnt  = 0;
  int  totalCnt = 0;

  // Monitor: one comparison per queued transaction, sampled mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon = sbq.pop_front();
      totalCnt++;
      if (stall === mon.st && flush === mon.fl && sleeping === mon.sl && stall_timeout === mon.tmo) begin
        passCnt++;
        $display("txn %-10s stall=%b flush=%b sleeping=%b timeout=%b ok",
                 mon.name, stall, flush, sleeping, stall_timeout);
      end else begin
        $display("FAIL %s: got stall=%b flush=%b sleeping=%b timeout=%b, expected stall=%b flush=%b sleeping=%b timeout=%b",
                 mon.name, stall, flush, sleeping, stall_timeout, mon.st, mon.fl, mon.sl, mon.tmo);
      end
    end
  end

  task automatic idle();
    stall_req = '0; stall_depth = '0; branch_flag = 0; excp_flag = 0;
    split16_flag = 0; fence_req = 0; lsu_busy = '0; wfi_req = 0; wake_req = 0;
  endtask

  task automatic setReq(input int idx, input int d);
    stall_req[idx] = 1'b1;
    stall_depth[idx*DW +: DW] = DW'(d);
  endtask

  task automatic cyc(input string nm, input logic [NS-1:0] st, input logic [NS-2:0] fl,
                     input logic sl, input logic tmo);
    expT e;
    e.name = nm; e.st = st; e.fl = fl; e.sl = sl; e.tmo = tmo;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst0", 5'b00000, 4'b1111, 0, 0);
    cyc("rst1", 5'b00000, 4'b1111, 0, 0);
    rst = 1'b0;
    cyc("idle", 5'b00000, 4'b0000, 0, 0);

    // requester merge
    setReq(0, 2); setReq(3, 4);
    cyc("merge", 5'b01111, 4'b1000, 0, 0);
    idle();
    cyc("release", 5'b00000, 4'b0000, 0, 0);
    setReq(1, 7);
    cyc("clamp", 5'b11111, 4'b0000, 0, 0);
    idle(); setReq(2, 0);
    cyc("depth0", 5'b00000, 4'b0000, 0, 0);
    idle(); setReq(4, 3); setReq(5, 1);
    cyc("mix13", 5'b00111, 4'b0100, 0, 0);
    idle(); split16_flag = 1;
    cyc("split", 5'b00000, 4'b0001, 0, 0);

    // fence drain
    idle(); fence_req = 1; lsu_busy = 5'b01000;
    for (int i = 0; i < 3; i++) cyc("fence", 5'b00011, 4'b0010, 0, 0);
    idle();
    cyc("fence_last", 5'b00011, 4'b0010, 0, 0);
    cyc("fence_done", 5'b00000, 4'b0000, 0, 0);

    // WFI sleep (wfi beats a pending fence)
    wfi_req = 1; fence_req = 1; lsu_busy = 5'b01000;
    cyc("wfi_prio", 5'b00000, 4'b0000, 0, 0);
    idle();
    cyc("sleep", 5'b11111, 4'b0000, 1, 0);
    setReq(0, 3);
    for (int i = 0; i < 9; i++) cyc("sleep_wd", 5'b11111, 4'b0000, 1, 0);
    idle(); wake_req = 1;
    cyc("wake", 5'b11111, 4'b0000, 1, 0);
    idle();
    cyc("awake", 5'b00000, 4'b0000, 0, 0);
    wfi_req = 1; wake_req = 1;
    cyc("wfi_wake", 5'b00000, 4'b0000, 0, 0);
    idle();
    cyc("no_sleep", 5'b00000, 4'b0000, 0, 0);

    // redirect hold (REDIRECT_HOLD=3)
    branch_flag = 1;
    cyc("br0", 5'b00000, 4'b0011, 0, 0);
    idle(); setReq(0, 3);
    cyc("br1", 5'b00111, 4'b0111, 0, 0);
    idle();
    cyc("br2", 5'b00000, 4'b0011, 0, 0);
    cyc("br3", 5'b00000, 4'b0000, 0, 0);
    branch_flag = 1;
    cyc("br2_c0", 5'b00000, 4'b0011, 0, 0);
    idle();
    cyc("br2_c1", 5'b00000, 4'b0011, 0, 0);
    branch_flag = 1;
    cyc("br2_c2", 5'b00000, 4'b0011, 0, 0);
    idle();
    cyc("br2_c3", 5'b00000, 4'b0011, 0, 0);
    cyc("br2_c4", 5'b00000, 4'b0011, 0, 0);
    cyc("br2_c5", 5'b00000, 4'b0000, 0, 0);

    // exception wakes the core and flushes
    wfi_req = 1;
    cyc("e_wfi", 5'b00000, 4'b0000, 0, 0);
    idle(); excp_flag = 1;
    cyc("e_sleep", 5'b11111, 4'b0011, 1, 0);
    idle();
    cyc("e_run1", 5'b00000, 4'b0011, 0, 0);
    cyc("e_run2", 5'b00000, 4'b0011, 0, 0);
    cyc("e_run3", 5'b00000, 4'b0000, 0, 0);

    // watchdog (TIMEOUT=8)
    setReq(0, 1);
    for (int i = 0; i < 8; i++) cyc("wd", 5'b00001, 4'b0001, 0, 0);
    cyc("wd_trip", 5'b00001, 4'b0001, 0, 1);
    cyc("wd_hold", 5'b00001, 4'b0001, 0, 1);
    idle();
    cyc("wd_drop", 5'b00000, 4'b0000, 0, 1);
    cyc("wd_clr", 5'b00000, 4'b0000, 0, 0);

    // reset mid-sleep with a partially counted watchdog
    setReq(0, 1);
    for (int i = 0; i < 5; i++) cyc("r_pre", 5'b00001, 4'b0001, 0, 0);
    wfi_req = 1;
    cyc("r_wfi", 5'b00001, 4'b0001, 0, 0);
    wfi_req = 0;
    cyc("r_sleep", 5'b11111, 4'b0000, 1, 0);
    rst = 1;
    cyc("r_rst", 5'b00000, 4'b1111, 0, 0);
    rst = 0;
    for (int i = 0; i < 8; i++) cyc("r_post", 5'b00001, 4'b0001, 0, 0);
    cyc("r_trip", 5'b00001, 4'b0001, 0, 1);
    idle();
    cyc("r_drop", 5'b00000, 4'b0000, 0, 1);
    cyc("r_end", 5'b00000, 4'b0000, 0, 0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      totalCnt++;
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
